// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 receiver plus ASCII command-line parser (letter, optional decimal, CR).
// Optional echo path enabled by defining UART_RX_ECHO_EN.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxData,
    output logic [7:0] rxByte,
    output logic       rxByteValid,
    output logic       frameErr,
    output logic       cmdValid,
    output logic [2:0] cmdCode,
    output logic [7:0] cmdArg,
    output logic       cmdErr,
    output logic [7:0] echoData,
    output logic       echoValid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        P_CMD   = 2'd0,
        P_ARG   = 2'd1,
        P_FLUSH = 2'd2
    } p_state_t;

    // Returns {valid, code} for an already case-folded command letter.
    function automatic logic [3:0] decode_letter(input logic [7:0] b);
        case (b)
            8'h46:   return {1'b1, 3'd0};
            8'h42:   return {1'b1, 3'd1};
            8'h4C:   return {1'b1, 3'd2};
            8'h52:   return {1'b1, 3'd3};
            8'h48:   return {1'b1, 3'd4};
            8'h53:   return {1'b1, 3'd5};
            default: return 4'd0;
        endcase
    endfunction

    logic            r_sync1, r_sync2, r_sync3;
    rx_state_t       r_rx_state, w_rx_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            w_line, w_fall, w_cnt_zero;
    logic            w_sample, w_byte_ok, w_frame_bad;

    p_state_t        r_p_state, w_p_next;
    logic [2:0]      r_code;
    logic [9:0]      r_acc;
    logic [1:0]      r_ndig;
    logic [7:0]      w_fold;
    logic [3:0]      w_digit;
    logic [3:0]      w_letter;
    logic [9:0]      w_acc_next;
    logic            w_is_digit, w_is_cr, w_skip, w_pass, w_byte_in;
    logic            w_cmd_ok, w_cmd_bad;

    assign w_line     = r_sync2;
    assign w_fall     = r_sync3 & ~r_sync2;
    assign w_cnt_zero = (r_cnt == '0);

    // Line synchroniser; the third stage only serves falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rxData;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= R_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // Receiver next-state logic.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (w_fall) w_rx_next = R_START; else w_rx_next = R_IDLE;
            R_START: if (w_cnt_zero) w_rx_next = w_line ? R_IDLE : R_DATA;
                     else w_rx_next = R_START;
            R_DATA:  if (w_cnt_zero && r_bitcnt == 3'd7) w_rx_next = R_STOP;
                     else w_rx_next = R_DATA;
            R_STOP:  if (w_cnt_zero) w_rx_next = w_line ? R_IDLE : R_BREAK;
                     else w_rx_next = R_STOP;
            R_BREAK: if (w_line) w_rx_next = R_IDLE; else w_rx_next = R_BREAK;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // Receiver decoded events.
    always_comb begin
        w_sample    = (r_rx_state == R_DATA) && w_cnt_zero;
        w_byte_ok   = (r_rx_state == R_STOP) && w_cnt_zero && w_line;
        w_frame_bad = (r_rx_state == R_STOP) && w_cnt_zero && !w_line;
    end

    // Bit timer, bit counter and shift register; the idle reload sets the half-bit start check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    r_cnt    <= HALF_M1;
                    r_bitcnt <= 3'd0;
                end
                R_START, R_DATA, R_STOP: r_cnt <= w_cnt_zero ? FULL_M1 : r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_sample) begin
                r_shift  <= {w_line, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    // Registered receiver outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxByte      <= 8'd0;
            rxByteValid <= 1'b0;
            frameErr    <= 1'b0;
        end else begin
            rxByteValid <= w_byte_ok;
            frameErr    <= w_frame_bad;
            if (w_byte_ok) rxByte <= r_shift;
            else           rxByte <= rxByte;
        end
    end

    // Parser byte classification on the freshly received byte.
    always_comb begin
        if (rxByte >= 8'h61 && rxByte <= 8'h7A) w_fold = rxByte & 8'hDF;
        else                                     w_fold = rxByte;
        w_digit    = w_fold[3:0];
        w_is_digit = (w_fold >= 8'h30) && (w_fold <= 8'h39);
        w_is_cr    = (w_fold == 8'h0D);
        w_skip     = (w_fold == 8'h0A) || (w_fold == 8'h20);
        w_letter   = decode_letter(w_fold);
        w_acc_next = r_acc * 10'd10 + {6'd0, w_digit};
        w_byte_in  = rxByteValid && !w_skip;
        if (r_code == 3'd5) w_pass = (r_ndig != 2'd0) && (r_acc <= 10'd255);
        else                w_pass = (r_ndig == 2'd0);
    end

    // Parser state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_p_state <= P_CMD;
        else     r_p_state <= w_p_next;
    end

    // Parser next-state logic.
    always_comb begin
        w_p_next = r_p_state;
        if (frameErr) begin
            if (r_p_state != P_CMD) w_p_next = P_FLUSH;
            else                    w_p_next = P_CMD;
        end else if (w_byte_in) begin
            case (r_p_state)
                P_CMD: begin
                    if (w_letter[3])  w_p_next = P_ARG;
                    else if (w_is_cr) w_p_next = P_CMD;
                    else              w_p_next = P_FLUSH;
                end
                P_ARG: begin
                    if (w_is_digit)   w_p_next = (r_ndig == 2'd3) ? P_FLUSH : P_ARG;
                    else if (w_is_cr) w_p_next = P_CMD;
                    else              w_p_next = P_FLUSH;
                end
                P_FLUSH: if (w_is_cr) w_p_next = P_CMD; else w_p_next = P_FLUSH;
                default: w_p_next = P_CMD;
            endcase
        end else begin
            w_p_next = r_p_state;
        end
    end

    // Parser line verdict at CR.
    always_comb begin
        w_cmd_ok  = 1'b0;
        w_cmd_bad = 1'b0;
        if (w_byte_in && w_is_cr) begin
            if (r_p_state == P_ARG) begin
                w_cmd_ok  = w_pass;
                w_cmd_bad = !w_pass;
            end else if (r_p_state == P_FLUSH) begin
                w_cmd_bad = 1'b1;
            end else begin
                w_cmd_ok  = 1'b0;
            end
        end else begin
            w_cmd_bad = 1'b0;
        end
    end

    // Pending command code, argument accumulator and digit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= 3'd0;
            r_acc  <= 10'd0;
            r_ndig <= 2'd0;
        end else if (w_byte_in && !frameErr) begin
            if (r_p_state == P_CMD && w_letter[3]) begin
                r_code <= w_letter[2:0];
                r_acc  <= 10'd0;
                r_ndig <= 2'd0;
            end else if (r_p_state == P_ARG && w_is_digit && r_ndig != 2'd3) begin
                r_acc  <= w_acc_next;
                r_ndig <= r_ndig + 2'd1;
            end
        end
    end

    // Registered command outputs; code/arg hold between accepted commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmdValid <= 1'b0;
            cmdErr   <= 1'b0;
            cmdCode  <= 3'd0;
            cmdArg   <= 8'd0;
        end else begin
            cmdValid <= w_cmd_ok;
            cmdErr   <= w_cmd_bad;
            if (w_cmd_ok) begin
                cmdCode <= r_code;
                cmdArg  <= (r_code == 3'd5) ? r_acc[7:0] : 8'd0;
            end
        end
    end

`ifdef UART_RX_ECHO_EN
    // Echo each good byte alongside rxByteValid; a CR gets an LF on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echoData  <= 8'd0;
            echoValid <= 1'b0;
        end else if (w_byte_ok) begin
            echoData  <= r_shift;
            echoValid <= 1'b1;
        end else if (rxByteValid && rxByte == 8'h0D) begin
            echoData  <= 8'h0A;
            echoValid <= 1'b1;
        end else begin
            echoValid <= 1'b0;
        end
    end
`else
    assign echoData  = 8'd0;
    assign echoValid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx at 16 clk/bit: directed scenarios plus random lines
// checked against a line-level command model.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    localparam int CPB = 16;

    typedef struct {
        bit         ok;
        logic [2:0] code;
        logic [7:0] arg;
    } ev_t;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxData = 1'b1;
    logic [7:0] rxByte;
    logic       rxByteValid, frameErr, cmdValid, cmdErr, echoValid;
    logic [2:0] cmdCode;
    logic [7:0] cmdArg, echoData;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rxv = -10;
    int n_ferr = 0, n_lat_bad = 0, n_both = 0, n_echo_total = 0;
    logic [7:0] q_rx[$];
    logic [7:0] q_echo[$];
    ev_t        q_ev[$];

    uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rxData(rxData),
        .rxByte(rxByte), .rxByteValid(rxByteValid), .frameErr(frameErr),
        .cmdValid(cmdValid), .cmdCode(cmdCode), .cmdArg(cmdArg), .cmdErr(cmdErr),
        .echoData(echoData), .echoValid(echoValid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Observe outputs on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if ((cmdValid || cmdErr) && cyc != last_rxv + 1) n_lat_bad++;
            if (cmdValid && cmdErr) n_both++;
            if (cmdValid) q_ev.push_back('{1'b1, cmdCode, cmdArg});
            if (cmdErr) q_ev.push_back('{1'b0, 3'd0, 8'd0});
            if (rxByteValid) begin
                q_rx.push_back(rxByte);
                last_rxv = cyc;
            end
            if (frameErr) n_ferr++;
            if (echoValid) begin
                q_echo.push_back(echoData);
                n_echo_total++;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    task automatic clear_mon();
        q_rx.delete();
        q_ev.delete();
        q_echo.delete();
        n_ferr = 0;
    endtask

    task automatic idle(input int n);
        rxData = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxData = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxData = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxData = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    // Line-level model: bytes of one line (without CR) -> optional command event.
    function automatic bit model_line(input bq_t ln, output ev_t ev);
        logic [7:0] f[$];
        int  code, n, val;
        bit  alld;
        ev = '{1'b0, 3'd0, 8'd0};
        foreach (ln[i]) begin
            if (ln[i] != 8'd10 && ln[i] != 8'd32)
                f.push_back((ln[i] >= 8'd97 && ln[i] <= 8'd122) ? ln[i] - 8'd32 : ln[i]);
        end
        if (f.size() == 0) return 1'b0;
        case (f[0])
            "F": code = 0;  "B": code = 1;  "L": code = 2;
            "R": code = 3;  "H": code = 4;  "S": code = 5;
            default: code = -1;
        endcase
        n = f.size() - 1;
        val = 0;
        alld = 1'b1;
        for (int i = 1; i < f.size(); i++) begin
            if (f[i] >= 8'd48 && f[i] <= 8'd57) val = val * 10 + int'(f[i] - 8'd48);
            else alld = 1'b0;
        end
        if (code >= 0 && alld && n <= 3 &&
            ((code == 5) ? (n >= 1 && val <= 255) : (n == 0)))
            ev = '{1'b1, 3'(code), (code == 5) ? 8'(val) : 8'd0};
        return 1'b1;
    endfunction

    task automatic test_reset();
        idle(20);
        rst = 1'b0;
        idle(20);
        send_str("S7\r");
        idle(40);
        rxData = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxData = i[0];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rxByte !== 8'd0) begin
            $display("FAIL reset_rxByte: got %h required 00", rxByte); n_errors++;
        end
        n_checks++;
        if ({cmdCode, cmdArg} !== 11'd0) begin
            $display("FAIL reset_cmd: got code %0d arg %0d required 0 0", cmdCode, cmdArg); n_errors++;
        end
        n_checks++;
        if ({rxByteValid, frameErr, cmdValid, cmdErr, echoValid, echoData} !== 13'd0) begin
            $display("FAIL reset_flags: got %b required all 0",
                     {rxByteValid, frameErr, cmdValid, cmdErr, echoValid, echoData}); n_errors++;
        end
        rxData = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(20);
        clear_mon();
        send_str("H\r");
        idle(40);
        n_checks++;
        if (q_ev.size() != 1 || !q_ev[0].ok || q_ev[0].code !== 3'd4 || q_ev[0].arg !== 8'd0) begin
            $display("FAIL reset_then_H: got %0d events, required one cmdValid code 4 arg 0", q_ev.size());
            n_errors++;
        end
        n_checks++;
        if (q_rx.size() != 2 || q_rx[0] !== 8'h48 || q_rx[1] !== 8'h0D) begin
            $display("FAIL reset_discard: got %0d bytes, required 48 0D", q_rx.size()); n_errors++;
        end
    endtask

    task automatic test_basic_cmd();
        clear_mon();
        send_str("f\r");
        idle(40);
        n_checks++;
        if (q_ev.size() != 1 || !q_ev[0].ok || q_ev[0].code !== 3'd0 || q_ev[0].arg !== 8'd0) begin
            $display("FAIL cmd_f: got %0d events, required one cmdValid code 0 arg 0", q_ev.size());
            n_errors++;
        end
        n_checks++;
        if (q_rx.size() != 2 || q_rx[0] !== 8'h66 || q_rx[1] !== 8'h0D) begin
            $display("FAIL rxbytes_f: got %0d bytes, required 66 0D", q_rx.size()); n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_str("S120\r\n");
        idle(40);
        n_checks++;
        if (q_ev.size() != 1 || !q_ev[0].ok || q_ev[0].code !== 3'd5 || q_ev[0].arg !== 8'd120) begin
            $display("FAIL b2b_S120: got %0d events, required one cmdValid code 5 arg 120", q_ev.size());
            n_errors++;
        end
        n_checks++;
        if (q_rx.size() != 6 || q_rx[5] !== 8'h0A || q_rx[1] !== 8'h31) begin
            $display("FAIL b2b_bytes: got %0d bytes, required 6 ending 0A", q_rx.size()); n_errors++;
        end
    endtask

    task automatic test_rejects();
        int n_ok, n_bad;
        clear_mon();
        send_str("S300\r");
        send_str("S1234\r");
        send_str("S\r");
        send_str("L5\r");
        send_str("X\r");
        idle(40);
        n_ok = 0;
        n_bad = 0;
        foreach (q_ev[i]) if (q_ev[i].ok) n_ok++; else n_bad++;
        n_checks++;
        if (n_ok != 0 || n_bad != 5) begin
            $display("FAIL rejects: got %0d valid %0d err, required 0 valid 5 err", n_ok, n_bad);
            n_errors++;
        end
        n_checks++;
        if (cmdCode !== 3'd5 || cmdArg !== 8'd120) begin
            $display("FAIL reject_hold: got code %0d arg %0d required 5 120", cmdCode, cmdArg);
            n_errors++;
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_byte(8'h46, 1'b0);
        rxData = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle(32);
        n_checks++;
        if (n_ferr != 1 || q_rx.size() != 0) begin
            $display("FAIL frame_err: got %0d frameErr %0d bytes, required 1 0", n_ferr, q_rx.size());
            n_errors++;
        end
        send_str("R\r");
        idle(40);
        n_checks++;
        if (q_ev.size() != 1 || !q_ev[0].ok || q_ev[0].code !== 3'd3) begin
            $display("FAIL after_break_R: got %0d events, required one cmdValid code 3", q_ev.size());
            n_errors++;
        end
        clear_mon();
        send_str("S1");
        send_byte(8'h46, 1'b0);
        idle(40);
        send_str("2\r");
        idle(40);
        n_checks++;
        if (q_ev.size() != 1 || q_ev[0].ok || n_ferr != 1) begin
            $display("FAIL midline_frame_err: got %0d events ok=%0d, required one cmdErr",
                     q_ev.size(), (q_ev.size() > 0) ? q_ev[0].ok : 1'b0);
            n_errors++;
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rxData = 1'b0;
        repeat (6) @(negedge clk);
        idle(200);
        n_checks++;
        if (q_rx.size() != 0 || n_ferr != 0) begin
            $display("FAIL glitch: got %0d bytes %0d frameErr, required 0 0", q_rx.size(), n_ferr);
            n_errors++;
        end
    endtask

    task automatic test_echo();
        clear_mon();
        send_str("B\r");
        idle(40);
`ifdef UART_RX_ECHO_EN
        n_checks++;
        if (q_echo.size() != 3 || q_echo[0] !== 8'h42 || q_echo[1] !== 8'h0D || q_echo[2] !== 8'h0A) begin
            $display("FAIL echo: got %0d echo bytes, required 42 0D 0A", q_echo.size()); n_errors++;
        end
`else
        n_checks++;
        if (n_echo_total != 0 || echoData !== 8'd0) begin
            $display("FAIL echo_off: got %0d strobes data %h, required 0 00", n_echo_total, echoData);
            n_errors++;
        end
`endif
    endtask

    task automatic test_random();
        string letters = "FBLRHSfblrhsX1";
        ev_t   exp_q[$];
        ev_t   ev;
        bq_t   ln;
        int    nd, mism;
        clear_mon();
        for (int l = 0; l < 20; l++) begin
            ln.delete();
            ln.push_back(letters[$urandom_range(0, 13)]);
            if ($urandom_range(0, 3) == 0) ln.push_back(8'h20);
            nd = $urandom_range(0, 4);
            for (int d = 0; d < nd; d++)
                ln.push_back(8'h30 + 8'($urandom_range(0, (d == 0) ? 3 : 9)));
            foreach (ln[i]) send_byte(ln[i], 1'b1);
            send_byte(8'h0D, 1'b1);
            if ($urandom_range(0, 1) == 1) send_byte(8'h0A, 1'b1);
            if (model_line(ln, ev)) exp_q.push_back(ev);
            idle($urandom_range(0, 20));
        end
        idle(40);
        n_checks++;
        if (q_ev.size() != exp_q.size()) begin
            $display("FAIL random_count: got %0d events required %0d", q_ev.size(), exp_q.size());
            n_errors++;
        end else begin
            mism = 0;
            foreach (exp_q[i]) begin
                if (q_ev[i].ok !== exp_q[i].ok || q_ev[i].code !== exp_q[i].code ||
                    q_ev[i].arg !== exp_q[i].arg) begin
                    $display("FAIL random_ev%0d: got ok %0d code %0d arg %0d required ok %0d code %0d arg %0d",
                             i, q_ev[i].ok, q_ev[i].code, q_ev[i].arg,
                             exp_q[i].ok, exp_q[i].code, exp_q[i].arg);
                    mism++;
                end
            end
            if (mism != 0) n_errors++;
        end
    endtask

    task automatic test_timing();
        n_checks++;
        if (n_lat_bad != 0 || n_both != 0) begin
            $display("FAIL cmd_timing: got %0d late %0d overlapping pulses, required 0 0",
                     n_lat_bad, n_both);
            n_errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_cmd();
        test_back_to_back();
        test_rejects();
        test_frame_err();
        test_glitch();
        test_echo();
        test_random();
        test_timing();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
